mac_sequencer: RTL and testbench

- Controller that runs one dot-product job on the existing generic MAC datapath (multiplier feeding an accumulator).
- On a start request it clears the accumulator, then streams LEN operand-pair reads from two synchronous-read operand RAMs.
- It raises newData for each product as that product reaches the accumulator, drains the pipeline, and captures the accumulated result.
- Sits between the job-issuing logic and the MAC instance.

---
 rtl/mac_seq_pkg.sv | 25 ++
 rtl/mac_seq_vpipe.sv | 30 +++
 rtl/mac_sequencer.sv | 126 ++++++++++++
 tb/tb_mac_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC job sequencer.
// The optional stall input is enabled by defining MAC_SEQ_STALL_EN.
package mac_seq_pkg;

  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_LEN_W      = 9;
  localparam int DEF_ACC_CYCLES = 400;
  localparam int DEF_RES_W      = 25;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_MULT_LAT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    CAPTURE
  } seqState_t;

  // A read strobe becomes an accumulate strobe after RAM and multiplier latency.
  function automatic int pipeDepth(input int memLat, input int multLat);
    return memLat + multLat;
  endfunction

endpackage

// File: rtl/mac_seq_vpipe.sv
// Valid shift register of configurable depth; hold freezes every stage.
// Used by mac_sequencer to turn RAM read strobes into accumulate strobes.
module mac_seq_vpipe #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic vldIn,
  output logic vldOut,
  output logic anyVld
);

  logic [DEPTH-1:0] vldPipe;

  always_ff @(posedge clock) begin
    if (!reset) begin
      vldPipe <= '0;
    end else if (!hold) begin
      vldPipe[0] <= vldIn;
      for (int i = 1; i < DEPTH; i++) begin
        vldPipe[i] <= vldPipe[i-1];
      end
    end
  end

  assign vldOut = vldPipe[DEPTH-1];
  assign anyVld = |vldPipe;

endmodule

// File: rtl/mac_sequencer.sv
// Runs one dot-product job on an external MAC: clear, stream LEN reads, drain, capture.
// Define MAC_SEQ_STALL_EN to add a stall input that freezes FETCH/DRAIN.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int ACC_CYCLES = DEF_ACC_CYCLES,
  parameter int RES_W      = DEF_RES_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MULT_LAT   = DEF_MULT_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef MAC_SEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mac_enable,
  output logic              mac_clear,
  output logic              mac_new_data,
  input  logic [RES_W-1:0]  acc_in,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  localparam int PIPE_DEPTH = pipeDepth(MEM_LAT, MULT_LAT);

  seqState_t         state, nextState;
  logic [ADDR_W-1:0] addrCnt;
  logic [LEN_W-1:0]  lenCnt;
  logic              zeroJob;
  logic [RES_W-1:0]  resultReg;
  logic              stallIn, hold;
  logic              pipeOut, pipeAny;

  // Saturate the requested length to the accumulator's safe product count.
  function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] l);
    if (32'(l) > 32'(ACC_CYCLES)) return LEN_W'(ACC_CYCLES);
    return l;
  endfunction

`ifdef MAC_SEQ_STALL_EN
  assign stallIn = stall;
`else
  assign stallIn = 1'b0;
`endif

  assign hold = stallIn && ((state == FETCH) || (state == DRAIN));

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = (len == '0) ? CAPTURE : CLEAR;
      CLEAR:   nextState = FETCH;
      FETCH:   if (!hold && (lenCnt == LEN_W'(1))) nextState = DRAIN;
      // The empty-pipe cycle gives the accumulator time to register the last product.
      DRAIN:   if (!hold && !pipeAny) nextState = CAPTURE;
      CAPTURE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rd_en        = 1'b0;
    mac_enable   = 1'b0;
    mac_clear    = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE:    busy = 1'b0;
      CLEAR:   begin mac_clear = 1'b1; mac_enable = 1'b1; end
      FETCH:   begin rd_en = !hold; mac_enable = !hold; end
      DRAIN:   mac_enable = !hold;
      CAPTURE: begin result_valid = 1'b1; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  assign rd_addr      = addrCnt;
  assign mac_new_data = pipeOut && !hold;
  assign result       = resultReg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      addrCnt   <= '0;
      lenCnt    <= '0;
      zeroJob   <= 1'b0;
      resultReg <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        addrCnt <= base_addr;
        lenCnt  <= clampLen(len);
        zeroJob <= (len == '0);
      end else if ((state == FETCH) && !hold) begin
        addrCnt <= addrCnt + ADDR_W'(1);
        lenCnt  <= lenCnt - LEN_W'(1);
      end
      if (state == CAPTURE) resultReg <= zeroJob ? '0 : acc_in;
    end
  end

  mac_seq_vpipe #(
    .DEPTH(PIPE_DEPTH)
  ) uVpipe (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .vldIn (rd_en),
    .vldOut(pipeOut),
    .anyVld(pipeAny)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural RAM/multiplier/accumulator environment.
// Stall scenarios are exercised when MAC_SEQ_STALL_EN is defined.
module tb_mac_sequencer;

  localparam int RES_W = 25;
  localparam int PLAT  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [8:0]       baseAddr = '0;
  logic [8:0]       jobLen = '0;
  logic             rd_en, mac_enable, mac_clear, mac_new_data;
  logic [8:0]       rd_addr;
  logic [RES_W-1:0] acc, result;
  logic             result_valid, busy, done;

  logic [7:0]  ramA [512];
  logic [7:0]  ramB [512];
  logic [7:0]  aQ, bQ;
  logic [15:0] prod;

  int     cyc = 0;
  int     nChecks = 0;
  int     nPass = 0;
  int     ndCount = 0;
  int     doneCount = 0;
  bit     rvPrev = 1'b0;
  int     addrQ[$];
  longint resQ[$];

  mac_sequencer #(
    .ADDR_W(9), .LEN_W(9), .ACC_CYCLES(400), .RES_W(RES_W), .MEM_LAT(1), .MULT_LAT(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef MAC_SEQ_STALL_EN
    .stall(stall),
`endif
    .base_addr(baseAddr), .len(jobLen),
    .rd_en(rd_en), .rd_addr(rd_addr), .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_new_data(mac_new_data), .acc_in(acc), .result(result),
    .result_valid(result_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment: registered RAM read, enabled multiplier register, accumulator.
  always @(posedge clock) begin
    if (rd_en) begin
      aQ <= ramA[rd_addr];
      bQ <= ramB[rd_addr];
    end
    if (mac_enable) prod <= aQ * bQ;
    if (mac_clear) acc <= '0;
    else if (mac_new_data) acc <= acc + RES_W'(prod);
  end

  always @(negedge clock) begin
    if (rvPrev) resQ.push_back(longint'(result));
    rvPrev = result_valid;
    if (rd_en) addrQ.push_back(int'(rd_addr));
    if (mac_new_data) ndCount++;
    if (done) doneCount++;
  end

  task automatic check(input string name, input longint got, input longint exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int effLen(input int lenV);
    return (lenV > 400) ? 400 : lenV;
  endfunction

  function automatic longint modelDot(input int base, input int lenV);
    logic [RES_W-1:0] s = '0;
    for (int k = 0; k < effLen(lenV); k++)
      s = s + RES_W'(ramA[(base + k) % 512]) * RES_W'(ramB[(base + k) % 512]);
    return longint'(s);
  endfunction

  function automatic int modelLat(input int lenV, input int stallLen);
    return (lenV == 0) ? 1 : effLen(lenV) + PLAT + 3 + stallLen;
  endfunction

  task automatic clearMon();
    addrQ.delete();
    resQ.delete();
    ndCount = 0;
    doneCount = 0;
  endtask

  task automatic runJob(input int base, input int lenV, input int stallAt, input int stallLen,
                        input int extraAt, input int tail, output int lat);
    int startCyc;
    int rel;
    @(posedge clock); #1;
    start = 1'b1; baseAddr = 9'(base); jobLen = 9'(lenV); startCyc = cyc;
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      rel = cyc - startCyc;
      start = (rel == extraAt);
      stall = (rel >= stallAt) && (rel < stallAt + stallLen);
      if (done) begin lat = rel; break; end
    end
    start = 1'b0; stall = 1'b0;
    check("doneSeen", longint'(lat >= 0), 1);
    repeat (tail) begin @(posedge clock); #1; end
  endtask

  task automatic checkJob(input string tag, input int base, input int lenV, input int lat,
                          input int expCount, input int expLat, input longint expRes);
    int mism = 0;
    check({tag, "_lat"}, lat, expLat);
    check({tag, "_reads"}, addrQ.size(), expCount);
    check({tag, "_newData"}, ndCount, expCount);
    check({tag, "_dones"}, doneCount, 1);
    foreach (addrQ[k]) if (addrQ[k] != (base + k) % 512) mism++;
    check({tag, "_addrs"}, mism, 0);
    check({tag, "_result"}, (resQ.size() == 1) ? resQ[0] : -1, expRes);
  endtask

  typedef struct {
    int     base;
    int     lenV;
    int     expCount;
    int     expLat;
    longint expRes;   // -1: take from the reference model
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, lat2, b, l, sl, sa;
    longint r;
    for (int i = 0; i < 512; i++) begin
      ramA[i] = (i < 4) ? 8'(i + 1) : 8'($urandom);
      ramB[i] = (i < 4) ? 8'(i + 5) : 8'($urandom);
    end
    vecs[0] = '{0,   4,   4,   9,   70};
    vecs[1] = '{0,   0,   0,   1,   0};
    vecs[2] = '{500, 511, 400, 405, -1};
    vecs[3] = '{511, 1,   1,   6,   -1};
    vecs[4] = '{100, 400, 400, 405, -1};
    vecs[5] = '{37,  401, 400, 405, -1};

    repeat (3) @(posedge clock);
    #1;
    check("rstCtl", {rd_en, mac_enable, mac_clear, mac_new_data, result_valid, busy, done}, 0);
    check("rstAddr", rd_addr, 0);
    check("rstResult", result, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      clearMon();
      runJob(vecs[i].base, vecs[i].lenV, 0, 0, -1, 3, lat);
      r = (vecs[i].expRes < 0) ? modelDot(vecs[i].base, vecs[i].lenV) : vecs[i].expRes;
      checkJob($sformatf("vec%0d", i), vecs[i].base, vecs[i].lenV, lat,
               vecs[i].expCount, vecs[i].expLat, r);
    end

    // Start during FETCH is ignored; a start right after done is accepted.
    clearMon();
    runJob(16, 6, 0, 0, 4, 0, lat);
    runJob(40, 5, 0, 0, -1, 3, lat2);
    check("busyLat1", lat, 11);
    check("busyLat2", lat2, 10);
    check("busyDones", doneCount, 2);
    check("busyNewData", ndCount, 11);
    check("busyReads", addrQ.size(), 11);
    check("busyRes1", (resQ.size() == 2) ? resQ[0] : -1, modelDot(16, 6));
    check("busyRes2", (resQ.size() == 2) ? resQ[1] : -1, modelDot(40, 5));

    // Reset mid-FETCH aborts the job silently.
    clearMon();
    @(posedge clock); #1;
    start = 1'b1; baseAddr = 9'd8; jobLen = 9'd20;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("midRstCtl", {rd_en, mac_enable, mac_clear, mac_new_data, result_valid, busy, done}, 0);
    check("midRstAddr", rd_addr, 0);
    check("midRstResult", result, 0);
    repeat (40) begin @(posedge clock); #1; end
    check("midRstNoDone", doneCount, 0);
    clearMon();
    runJob(0, 4, 0, 0, -1, 3, lat);
    checkJob("afterRst", 0, 4, lat, 4, 9, 70);

`ifdef MAC_SEQ_STALL_EN
    clearMon();
    runJob(0, 4, 3, 3, -1, 3, lat);
    checkJob("stallBasic", 0, 4, lat, 4, 12, 70);
`endif

    for (int j = 0; j < 12; j++) begin
      b = $urandom_range(0, 511);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(380, 511) : $urandom_range(0, 30);
      sl = 0;
      sa = 0;
`ifdef MAC_SEQ_STALL_EN
      if (l != 0) begin
        sl = $urandom_range(0, 4);
        sa = $urandom_range(2, effLen(l) + 1);
      end
`endif
      clearMon();
      runJob(b, l, sa, sl, -1, 3, lat);
      checkJob($sformatf("rnd%0d", j), b, l, lat, effLen(l), modelLat(l, sl), modelDot(b, l));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
